// File: rtl/qr_frame_capture_writer.sv
// qr_frame_capture_writer: aligns a 1-bit pixel stream to SOF, writes one raster-order frame, then hands off to the finder
module qr_frame_capture_writer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        arm_in,
    input  logic        pixel_valid,
    input  logic        pixel_data,
    input  logic        sof,
    input  logic        eol,
    input  logic        finder_done,
    output logic [19:0] mem_addr,
    output logic        mem_data,
    output logic        mem_we,
    output logic        start_finder,
    output logic        capturing,
    output logic        frame_error,
    output logic [7:0]  frame_count
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, SYNC, CAPTURE, HANDOFF, WAIT_FINDER} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [19:0]   addr;
    logic          x_last;
    logic          y_last;

    always_comb begin
        x_last = x == X_LAST;
        y_last = y == Y_LAST;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            addr         <= '0;
            mem_addr     <= '0;
            mem_data     <= 1'b0;
            mem_we       <= 1'b0;
            start_finder <= 1'b0;
            capturing    <= 1'b0;
            frame_error  <= 1'b0;
            frame_count  <= '0;
        end else begin
            mem_we       <= 1'b0;
            start_finder <= 1'b0;
            case (state)
                IDLE: if (arm_in) begin
                    state       <= SYNC;
                    frame_error <= 1'b0;
                end
                SYNC, CAPTURE: if (pixel_valid) begin
                    // an SOF mid-frame is flagged but still restarts capture on the same beat
                    if (sof) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= '0;
                        mem_data  <= pixel_data;
                        addr      <= 20'd1;
                        x         <= XW'(1);
                        y         <= '0;
                        state     <= CAPTURE;
                        capturing <= 1'b1;
                        if (state == CAPTURE) frame_error <= 1'b1;
                    end else if (state == CAPTURE) begin
                        if (eol != x_last) begin
                            frame_error <= 1'b1;
                            state       <= SYNC;
                            capturing   <= 1'b0;
                        end else begin
                            mem_we   <= 1'b1;
                            mem_addr <= addr;
                            mem_data <= pixel_data;
                            addr     <= addr + 20'd1;
                            x        <= eol ? '0 : x + XW'(1);
                            y        <= eol ? y + YW'(1) : y;
                            if (eol && y_last) begin
                                state     <= HANDOFF;
                                capturing <= 1'b0;
                            end
                        end
                    end
                end
                HANDOFF: begin
                    start_finder <= 1'b1;
                    state        <= WAIT_FINDER;
                end
                WAIT_FINDER: if (finder_done) begin
                    frame_count <= frame_count + 8'd1;
                    state       <= arm_in ? SYNC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
